// File: rtl/fifo_rr_drain_pkg.sv
// Shared types and default sizing for the round-robin FIFO drain scheduler.
package fifo_rr_drain_pkg;

  localparam int unsigned DEF_N_PORT  = 4;
  localparam int unsigned DEF_D_WIDTH = 32;
  localparam int unsigned DEF_BURST   = 4;

  localparam int unsigned PTR_W = $clog2(DEF_N_PORT);
  localparam int unsigned CNT_W = $clog2(DEF_BURST + 1);

  // Enum literals carry an S_ prefix so they cannot collide with the BURST parameter.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_rr_drain_rr_pick.sv
// Round-robin picker: first requesting index after ptr_i, wrapping, ptr_i itself last.
module fifo_rr_drain_rr_pick
  import fifo_rr_drain_pkg::*;
#(
  parameter int unsigned N_PORT = DEF_N_PORT,
  parameter int unsigned PTR_W  = $clog2(N_PORT)
) (
  input  logic [N_PORT-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic              found_c_o,
  output logic [PTR_W-1:0]  idx_c_o
);

  always_comb begin
    int unsigned cand;
    cand      = 0;
    found_c_o = 1'b0;
    idx_c_o   = '0;
    for (int unsigned i = 1; i <= N_PORT; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= N_PORT) cand = cand - N_PORT;
      if (!found_c_o && req_i[PTR_W'(cand)]) begin
        found_c_o = 1'b1;
        idx_c_o   = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain.sv
// Drains N_PORT read-latency-1 FIFOs round-robin, bounded bursts, into one valid/ready stream.
module fifo_rr_drain
  import fifo_rr_drain_pkg::*;
#(
  parameter int unsigned N_PORT  = DEF_N_PORT,
  parameter int unsigned D_WIDTH = DEF_D_WIDTH,
  parameter int unsigned BURST   = DEF_BURST
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  output logic [N_PORT-1:0]         fifo_rd_en_o,
  input  logic [N_PORT*D_WIDTH-1:0] fifo_rd_data_i,
  input  logic [N_PORT-1:0]         fifo_rd_empty_i,
  output logic [D_WIDTH-1:0]        out_data_o,
  output logic [$clog2(N_PORT)-1:0] out_port_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i
);

  localparam int unsigned PORT_W = $clog2(N_PORT);
  localparam int unsigned BCNT_W = $clog2(BURST + 1);

  state_t             state_q, state_d;
  logic [PORT_W-1:0]  ptr_q, ptr_d, grant_q, grant_d, infl_port_q, infl_port_d;
  logic [BCNT_W-1:0]  beat_cnt_q, beat_cnt_d, beat_inc_c;
  logic               infl_q, infl_d;
  logic [1:0]         occ_q, occ_d;
  logic               valid_q, valid_d;
  logic [D_WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d, push_data_c;
  logic [PORT_W-1:0]  head_port_q, head_port_d, tail_port_q, tail_port_d;
  logic               pick_found_c;
  logic [PORT_W-1:0]  pick_idx_c;
  logic               pop_c, space_c, rd_c;

  fifo_rr_drain_rr_pick #(
    .N_PORT (N_PORT),
    .PTR_W  (PORT_W)
  ) u_pick (
    .req_i     (~fifo_rd_empty_i),
    .ptr_i     (ptr_q),
    .found_c_o (pick_found_c),
    .idx_c_o   (pick_idx_c)
  );

  // Read only if the skid buffer can absorb it once everything in flight has landed.
  assign pop_c        = valid_q & out_ready_i;
  assign space_c      = (3'(occ_q) + 3'(infl_q) - 3'(pop_c)) < 3'd2;
  assign rd_c         = (state_q == S_BURST) & ~fifo_rd_empty_i[grant_q] & space_c;
  assign fifo_rd_en_o = rd_c ? (N_PORT'(1) << grant_q) : '0;
  assign beat_inc_c   = beat_cnt_q + BCNT_W'(1);

  assign out_data_o  = head_data_q;
  assign out_port_o  = head_port_q;
  assign out_valid_o = valid_q;

  always_comb begin
    push_data_c = '0;
    for (int unsigned k = 0; k < N_PORT; k++) begin
      if (infl_port_q == PORT_W'(k)) push_data_c = fifo_rd_data_i[k*D_WIDTH +: D_WIDTH];
    end
  end

  // Skid buffer: head drives the output, pop shifts tail forward, returning read fills next slot.
  always_comb begin
    head_data_d = head_data_q;
    head_port_d = head_port_q;
    tail_data_d = tail_data_q;
    tail_port_d = tail_port_q;
    if (pop_c) begin
      head_data_d = tail_data_q;
      head_port_d = tail_port_q;
    end
    if (infl_q) begin
      if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop_c)) begin
        head_data_d = push_data_c;
        head_port_d = infl_port_q;
      end else begin
        tail_data_d = push_data_c;
        tail_port_d = infl_port_q;
      end
    end
    occ_d       = occ_q + 2'(infl_q) - 2'(pop_c);
    valid_d     = (occ_d != 2'd0);
    infl_d      = rd_c;
    infl_port_d = rd_c ? grant_q : infl_port_q;
  end

  // Grant FSM: pick in IDLE, issue up to BURST reads, leave on the last issue or on empty.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found_c) begin
          grant_d    = pick_idx_c;
          beat_cnt_d = '0;
          state_d    = S_BURST;
        end
      end
      S_BURST: begin
        if (fifo_rd_empty_i[grant_q]) begin
          state_d = S_IDLE;
          ptr_d   = grant_q;
        end else if (rd_c) begin
          beat_cnt_d = beat_inc_c;
          if (beat_inc_c == BCNT_W'(BURST)) begin
            state_d = S_IDLE;
            ptr_d   = grant_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      infl_q      <= 1'b0;
      infl_port_q <= '0;
      occ_q       <= '0;
      valid_q     <= 1'b0;
      head_data_q <= '0;
      head_port_q <= '0;
      tail_data_q <= '0;
      tail_port_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      infl_q      <= infl_d;
      infl_port_q <= infl_port_d;
      occ_q       <= occ_d;
      valid_q     <= valid_d;
      head_data_q <= head_data_d;
      head_port_q <= head_port_d;
      tail_data_q <= tail_data_d;
      tail_port_q <= tail_port_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Scoreboard bench for fifo_rr_drain: FIFO read-side model, expected-beat queue, output monitor.
module tb_fifo_rr_drain;
  import fifo_rr_drain_pkg::*;

  localparam int unsigned NP = DEF_N_PORT;
  localparam int unsigned DW = DEF_D_WIDTH;
  localparam int unsigned BL = DEF_BURST;

  typedef struct packed {
    logic [PTR_W-1:0] port;
    logic [DW-1:0]    data;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    rd_en;
  logic [NP*DW-1:0] rd_data = '0;
  logic [NP-1:0]    empty = '1;
  logic [DW-1:0]    out_data;
  logic [PTR_W-1:0] out_port;
  logic             out_valid;
  logic             out_ready = 1'b1;

  logic [DW-1:0] fq   [NP][$];
  logic [DW-1:0] pend [NP][$];
  beat_t         exp_q[$];
  int            rd_cyc_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rd_total = 0;
  int beats = 0;
  int rd_empty_err = 0;
  int seq = 0;

  always #5 clk = ~clk;

  fifo_rr_drain #(.N_PORT(NP), .D_WIDTH(DW), .BURST(BL)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .fifo_rd_en_o    (rd_en),
    .fifo_rd_data_i  (rd_data),
    .fifo_rd_empty_i (empty),
    .out_data_o      (out_data),
    .out_port_o      (out_port),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready)
  );

  // FIFO read side: rd_en at an edge presents the word after it; empty is registered.
  always @(posedge clk) begin
    logic [NP-1:0] e;
    logic [DW-1:0] w;
    for (int k = 0; k < NP; k++) begin
      if (rd_en[k]) begin
        if (fq[k].size() == 0) rd_empty_err = rd_empty_err + 1;
        else begin
          w = fq[k].pop_front();
          rd_data[k*DW +: DW] <= w;
        end
      end
    end
    for (int k = 0; k < NP; k++) e[k] = (fq[k].size() == 0);
    empty <= e;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic             stall = 1'b0;
    logic [DW-1:0]    pd = '0;
    logic [PTR_W-1:0] pp = '0;
    int               occ_m = 0;
    beat_t            b;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        stall = 1'b0;
        occ_m = 0;
        continue;
      end
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, pd);
        check("hold_port", out_port, pp);
      end
      if (rd_en != '0) begin
        check("rd_onehot", $countones(rd_en), 1);
        rd_total++;
        rd_cyc_q.push_back(cyc);
      end
      occ_m = occ_m + ((rd_en != '0) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (rd_en != '0) check("outstanding_le2", (occ_m <= 2), 1);
      if (out_valid && out_ready) begin
        beats++;
        if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
        else begin
          b = exp_q.pop_front();
          check("beat_port", out_port, b.port);
          check("beat_data", out_data, b.data);
        end
      end
      stall = out_valid & ~out_ready;
      pd    = out_data;
      pp    = out_port;
    end
  endtask

  task automatic load(input int k, input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = (DW'(k) << 24) | DW'(seq);
      seq++;
      fq[k].push_back(d);
      pend[k].push_back(d);
    end
  endtask

  task automatic expect_burst(input int k, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      if (pend[k].size() != 0) begin
        b.port = PTR_W'(k);
        b.data = pend[k].pop_front();
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < NP; k++) begin
      fq[k].delete();
      pend[k].delete();
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_rd_en", rd_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_port", out_port, 0);
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc_rd, acc_valid;
    int   r0, b0, e0, n;

    fork
      monitor();
    join_none

    // 1: idle with all FIFOs empty
    do_reset();
    acc_rd    = 1'b0;
    acc_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      acc_rd    = acc_rd | (rd_en != '0);
      acc_valid = acc_valid | out_valid;
    end
    check("t1_rd_en", acc_rd, 0);
    check("t1_valid", acc_valid, 0);

    // 2: single port, 10 words, bursts of 4 with one idle cycle between
    do_reset();
    rd_cyc_q.delete();
    load(2, 10);
    expect_burst(2, 10);
    drain("t2", 200);
    check("t2_reads", rd_cyc_q.size(), 10);
    if (rd_cyc_q.size() == 10) begin
      for (int i = 1; i < 10; i++)
        check($sformatf("t2_gap%0d", i), rd_cyc_q[i] - rd_cyc_q[i-1], ((i % 4) == 0) ? 2 : 1);
    end

    // 3: all ports loaded, rotation 1,2,3,0 twice
    do_reset();
    b0 = beats;
    for (int k = 0; k < NP; k++) load(k, 8);
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < NP; j++) expect_burst((j + 1) % NP, BL);
    drain("t3", 400);
    check("t3_beats", beats - b0, 32);

    // 4: ready toggling every cycle
    do_reset();
    b0 = beats;
    r0 = rd_total;
    load(0, 6);
    expect_burst(0, 6);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
      n++;
    end
    out_ready = 1'b1;
    drain("t4", 50);
    check("t4_beats", beats - b0, 6);
    check("t4_reads", rd_total - r0, 6);

    // 5: short burst ends on empty, then ptr=3 favours port0 over port1
    do_reset();
    e0 = rd_empty_err;
    r0 = rd_total;
    load(3, 2);
    expect_burst(3, 2);
    drain("t5a", 100);
    check("t5_reads", rd_total - r0, 2);
    load(0, 2);
    load(1, 2);
    expect_burst(0, 2);
    expect_burst(1, 2);
    drain("t5b", 100);
    check("t5_rd_on_empty", rd_empty_err - e0, 0);

    // 6: reset mid-burst with a read in flight, then scan restarts from ptr=0
    do_reset();
    r0 = rd_total;
    load(2, 6);
    expect_burst(2, 6);
    n = 0;
    while ((rd_total - r0) < 5 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t6_reach5", rd_total - r0, 5);
    rst_n = 1'b0;
    #1;
    check("t6_rd_en", rd_en, 0);
    check("t6_valid", out_valid, 0);
    check("t6_data", out_data, 0);
    check("t6_port", out_port, 0);
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    load(0, 4);
    load(1, 4);
    expect_burst(1, 4);
    expect_burst(0, 4);
    drain("t6", 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
